score_bcd_accum: RTL and testbench
==================================

// Module: score_bcd_accum
// PURPOSE
//   Per-team score register for the basketball scoreboard: turns +1/+2/+3,
//   -1 and clear button events into a 3-digit BCD score.
//   Sits directly upstream of the per-digit BCD-to-7-segment decoders:
//   hund_o, tens_o and ones_o each drive one decoder instance.
//   Multi-point adds are applied one unit per clock.
//   Digits are therefore always legal BCD, with no binary-to-BCD conversion.
// PARAMETERS
//   MAX_SCORE  199  highest displayable score, decimal, 1..999
//   WRAP       0    0: saturate at MAX_SCORE; 1: MAX_SCORE+1 wraps to 000
// PORTS
//   clk      in   1  system clock, all state on rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   add1_i   in   1  +1 button level (debounced, synchronous to clk)
//   add2_i   in   1  +2 button level
//   add3_i   in   1  +3 button level
//   sub1_i   in   1  -1 correction button level
//   clear_i  in   1  clear-score button level
//   hund_o   out  4  BCD hundreds digit
//   tens_o   out  4  BCD tens digit
//   ones_o   out  4  BCD ones digit
//   busy_o   out  1  high while a multi-unit add is in progress
//   limit_o  out  1  1-cycle pulse when an increment hits MAX_SCORE (sat or wrap)
// BEHAVIOUR
// - Reset (async, rst_n=0): digits 0/0/0, busy_o=0, limit_o=0, state IDLE,
//   remaining-count=0, edge-detect history regs=1 (button held at release ignored).
// - Each button is rising-edge detected internally (input=1 and previous sample=0).
//   Events are 1-cycle internal pulses.
// - FSM states are IDLE, INC and DEC.
// - IDLE: the highest-priority event is taken; all others in that cycle are dropped.
//   Priority order: clear > sub1 > add3 > add2 > add1.
//   - clear: digits <= 000 on the next edge; stay IDLE.
//   - sub1: go to DEC.
//   - addN: load remaining=N and go to INC. busy_o=1 from the next cycle.
// - INC: one +1 per cycle; remaining decrements each cycle.
//   Back to IDLE after the cycle where remaining=1.
//   An addN event seen in cycle C yields a final score visible after edge C+N.
//   busy_o drops in the same cycle as that final update.
// - DEC: one -1 applied, then back to IDLE.
//   At 000 nothing changes: no underflow, no wrap.
// - +1 arithmetic: ones 9->0 carries into tens; tens 9->0 carries into hundreds.
//   Digits never leave 0..9.
// - At MAX_SCORE with WRAP=0: score holds and limit_o pulses 1 cycle.
//   Any remaining units are discarded and the FSM returns to IDLE.
// - At MAX_SCORE with WRAP=1: score -> 000 and limit_o pulses 1 cycle.
//   Remaining units continue from 000.
// - While busy (INC): clear edges are honoured. Digits go to 000 and the add is aborted.
//   The next state is IDLE and busy_o=0 in the following cycle.
//   All other edges while busy are dropped, not queued.
// - Reset mid-operation: immediate return to the reset state; the partial add is lost.
// - Outputs are registered with no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package scoreboard_pkg:
//   - state enum {IDLE, INC, DEC};
//   - BCD_MAX = 4'd9;
//   - width constant BCD_W = 4.
//   The decoder side uses the same BCD_W.
// - Sub-module bcd_digit_step: one BCD digit +/-1 with carry_in/carry_out and
//   borrow_in/borrow_out, combinational. It is instanced three times in a ripple chain.
// - Top level contains the edge detectors, FSM, remaining counter, limit compare
//   and digit registers.
// TESTING
// - Reset, then add3 pulse -> digits step 001,002,003 on 3 consecutive edges.
//   busy_o=1 for exactly 3 cycles.
// - Score 098, add2 -> 099 then 100; both carries ripple correctly.
// - Score 198, add3, WRAP=0 -> 199 with one limit_o pulse; holds 199 and busy_o drops.
// - Same with WRAP=1 -> 199, 000 (limit_o pulse), 001.
// - Score 000, sub1 -> stays 000. Score 010, sub1 -> 009.
// - Mid-add3 after the first unit, assert clear -> 000 next edge and busy_o=0.
//   Simultaneous add1+add2 from IDLE -> only +2 applied.
//   Button held across rst_n release -> no count.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types and BCD constants.
// Also used by the downstream 7-segment decoder side.
package scoreboard_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        INC,
        DEC
    } state_t;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit stepped by +1 or -1 with ripple carry/borrow.
// Purely combinational; carry takes precedence over borrow.
module bcd_digit_step
    import scoreboard_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             carry_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_next,
    output logic             carry_out,
    output logic             borrow_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (carry_in) begin
            if (digit == BCD_MAX) begin
                digit_next = '0;
                carry_out  = 1'b1;
            end else begin
                digit_next = digit + 1'b1;
            end
        end else if (borrow_in) begin
            if (digit == '0) begin
                digit_next = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_bcd_accum.sv
// Per-team 3-digit BCD score register driven by +1/+2/+3, -1 and clear buttons.
// Multi-point adds step one unit per clock so digits stay legal BCD.
module score_bcd_accum
    import scoreboard_pkg::*;
#(
    parameter int MAX_SCORE = 199,
    parameter bit WRAP      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add1_i,
    input  logic             add2_i,
    input  logic             add3_i,
    input  logic             sub1_i,
    input  logic             clear_i,
    output logic [BCD_W-1:0] hund_o,
    output logic [BCD_W-1:0] tens_o,
    output logic [BCD_W-1:0] ones_o,
    output logic             busy_o,
    output logic             limit_o
);

    localparam logic [BCD_W-1:0] MAX_H = BCD_W'(MAX_SCORE / 100);
    localparam logic [BCD_W-1:0] MAX_T = BCD_W'((MAX_SCORE / 10) % 10);
    localparam logic [BCD_W-1:0] MAX_O = BCD_W'(MAX_SCORE % 10);

    state_t state;
    logic [1:0] remaining;
    logic [4:0] btn;
    logic [4:0] prev;
    logic [4:0] ev;
    logic [BCD_W-1:0] cur [3];
    logic [BCD_W-1:0] nxt [3];
    logic [3:0] carry;
    logic [3:0] borrow;
    logic at_max;

    // bit order: clear, sub1, add3, add2, add1
    assign btn = {clear_i, sub1_i, add3_i, add2_i, add1_i};
    assign ev  = btn & ~prev;

    assign cur[0] = ones_o;
    assign cur[1] = tens_o;
    assign cur[2] = hund_o;

    assign carry[0]  = (state == INC);
    assign borrow[0] = (state == DEC);

    for (genvar g = 0; g < 3; g++) begin : g_dig
        bcd_digit_step u_step (
            .digit      (cur[g]),
            .carry_in   (carry[g]),
            .borrow_in  (borrow[g]),
            .digit_next (nxt[g]),
            .carry_out  (carry[g+1]),
            .borrow_out (borrow[g+1])
        );
    end

    // carry out of the hundreds digit can only happen at 999, already the limit
    assign at_max = ((hund_o == MAX_H) && (tens_o == MAX_T) &&
                     (ones_o == MAX_O)) || carry[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '1;
            state     <= IDLE;
            remaining <= '0;
            hund_o    <= '0;
            tens_o    <= '0;
            ones_o    <= '0;
            busy_o    <= 1'b0;
            limit_o   <= 1'b0;
        end else begin
            prev    <= btn;
            limit_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev[4]) begin
                        hund_o <= '0;
                        tens_o <= '0;
                        ones_o <= '0;
                    end else if (ev[3]) begin
                        state <= DEC;
                    end else if (ev[2]) begin
                        remaining <= 2'd3;
                        state     <= INC;
                        busy_o    <= 1'b1;
                    end else if (ev[1]) begin
                        remaining <= 2'd2;
                        state     <= INC;
                        busy_o    <= 1'b1;
                    end else if (ev[0]) begin
                        remaining <= 2'd1;
                        state     <= INC;
                        busy_o    <= 1'b1;
                    end
                end
                INC: begin
                    if (ev[4]) begin
                        hund_o    <= '0;
                        tens_o    <= '0;
                        ones_o    <= '0;
                        remaining <= '0;
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                    end else if (at_max && !WRAP) begin
                        limit_o   <= 1'b1;
                        remaining <= '0;
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                    end else begin
                        if (at_max) begin
                            limit_o <= 1'b1;
                            hund_o  <= '0;
                            tens_o  <= '0;
                            ones_o  <= '0;
                        end else begin
                            hund_o <= nxt[2];
                            tens_o <= nxt[1];
                            ones_o <= nxt[0];
                        end
                        remaining <= remaining - 2'd1;
                        if (remaining == 2'd1) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                DEC: begin
                    // a borrow out of hundreds means the score was 000
                    if (!borrow[3]) begin
                        hund_o <= nxt[2];
                        tens_o <= nxt[1];
                        ones_o <= nxt[0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Scoreboard bench: saturating and wrapping instances against an integer model.
module tb_score_bcd_accum;
    localparam int MAX = 199;

    logic clk;
    logic rst_n;
    logic add1, add2, add3, sub1, clr;
    logic [3:0] hund [2];
    logic [3:0] tens [2];
    logic [3:0] ones [2];
    logic busy [2];
    logic limit [2];

    typedef struct {
        int score;
        bit busy;
        bit limit;
    } exp_t;

    exp_t q [2][$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_score [2];
    int m_pend [2];
    bit m_dec [2];
    bit m_lim [2];
    logic [4:0] m_prev [2];

    score_bcd_accum #(.MAX_SCORE(MAX), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .add1_i(add1), .add2_i(add2), .add3_i(add3),
        .sub1_i(sub1), .clear_i(clr),
        .hund_o(hund[0]), .tens_o(tens[0]), .ones_o(ones[0]),
        .busy_o(busy[0]), .limit_o(limit[0])
    );

    score_bcd_accum #(.MAX_SCORE(MAX), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .add1_i(add1), .add2_i(add2), .add3_i(add3),
        .sub1_i(sub1), .clear_i(clr),
        .hund_o(hund[1]), .tens_o(tens[1]), .ones_o(ones[1]),
        .busy_o(busy[1]), .limit_o(limit[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void mreset(int i);
        m_score[i] = 0;
        m_pend[i]  = 0;
        m_dec[i]   = 1'b0;
        m_lim[i]   = 1'b0;
        m_prev[i]  = 5'b11111;
    endfunction

    // b = {clear, sub1, add3, add2, add1}
    function automatic void mstep(int i, logic [4:0] b);
        logic [4:0] ev;
        ev = b & ~m_prev[i];
        m_prev[i] = b;
        m_lim[i] = 1'b0;
        if (m_pend[i] > 0) begin
            if (ev[4]) begin
                m_score[i] = 0;
                m_pend[i] = 0;
            end else if (m_score[i] == MAX) begin
                m_lim[i] = 1'b1;
                if (i == 1) begin
                    m_score[i] = 0;
                    m_pend[i]--;
                end else begin
                    m_pend[i] = 0;
                end
            end else begin
                m_score[i]++;
                m_pend[i]--;
            end
        end else if (m_dec[i]) begin
            if (m_score[i] > 0) m_score[i]--;
            m_dec[i] = 1'b0;
        end else if (ev[4]) m_score[i] = 0;
        else if (ev[3]) m_dec[i] = 1'b1;
        else if (ev[2]) m_pend[i] = 3;
        else if (ev[1]) m_pend[i] = 2;
        else if (ev[0]) m_pend[i] = 1;
    endfunction

    function automatic void push(int i);
        exp_t e;
        e.score = m_score[i];
        e.busy  = (m_pend[i] > 0);
        e.limit = m_lim[i];
        q[i].push_back(e);
    endfunction

    task automatic tick(input logic [4:0] b, input logic rst = 1'b1);
        @(negedge clk);
        rst_n = rst;
        {clr, sub1, add3, add2, add1} = b;
        for (int i = 0; i < 2; i++) begin
            if (!rst) mreset(i);
            else mstep(i, b);
            push(i);
        end
    endtask

    task automatic press(input logic [4:0] b);
        tick(b);
        tick(5'b0);
        for (int k = 0; k < 8; k++) begin
            if (m_pend[0] == 0 && m_pend[1] == 0 && !m_dec[0] && !m_dec[1]) break;
            tick(5'b0);
        end
        tick(5'b0);
    endtask

    task automatic set_score(input int t);
        press(5'b10000);
        repeat (t / 3) press(5'b00100);
        repeat (t % 3) press(5'b00001);
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0) begin
                exp_t e;
                int got;
                e = q[i].pop_front();
                got = hund[i] * 100 + tens[i] * 10 + ones[i];
                checks++;
                if (got != e.score || hund[i] > 9 || tens[i] > 9 || ones[i] > 9 ||
                    busy[i] != e.busy || limit[i] != e.limit) begin
                    errors++;
                    $display("FAIL dut%0d cyc %0d: got %0d%0d%0d busy=%0b lim=%0b, exp %0d busy=%0b lim=%0b",
                             i, cyc, hund[i], tens[i], ones[i], busy[i], limit[i],
                             e.score, e.busy, e.limit);
                end
            end
        end
    end

    initial begin
        logic [4:0] b;
        rst_n = 1'b0;
        {clr, sub1, add3, add2, add1} = 5'b0;
        // button held across reset release must not count
        repeat (3) tick(5'b00001, 1'b0);
        repeat (3) tick(5'b00001);
        tick(5'b0);
        press(5'b00100);
        set_score(98);
        press(5'b00010);
        set_score(198);
        press(5'b00100);
        press(5'b10000);
        press(5'b01000);
        set_score(10);
        press(5'b01000);
        // clear after the first unit of an add3
        tick(5'b00100);
        tick(5'b0);
        tick(5'b10000);
        tick(5'b0);
        tick(5'b0);
        press(5'b00011);
        set_score(190);
        for (int n = 0; n < 1500; n++) begin
            b = 5'b0;
            if ($urandom_range(0, 3) == 0) b = 5'($urandom_range(0, 31));
            if (b[4] && $urandom_range(0, 3) != 0) b[4] = 1'b0;
            if ($urandom_range(0, 299) == 0) tick(5'($urandom_range(0, 31)), 1'b0);
            else tick(b);
        end
        tick(5'b0);
        for (int k = 0; k < 10; k++) begin
            if (q[0].size() == 0 && q[1].size() == 0) break;
            @(posedge clk);
        end
        #2;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d left, exp 0", q[0].size(), q[1].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
